// File: rtl/mul_seq.sv
// mul_seq -- multi-cycle shift-add multiply sequencer for the 8-bit CPU datapath.
//
// Accepts a multiply request in IDLE, holds the PC via 'stall' while the
// n-iteration shift-add loop runs, and presents the 2n-bit product in the
// single DONE cycle in which the PC is released.
//
// Configuration macro: MUL_SIGNED_EN
//   defined     - 'signed_op' selects two's-complement operands; sign/magnitude
//                 conversion and the final negation are built.
//   not defined - 'signed_op' is ignored, all operands are unsigned.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   reset      in   1    synchronous active-high reset
//   start      in   1    multiply request (level, honoured only in IDLE)
//   a_in       in   n    multiplicand (Rd_data)
//   b_in       in   n    multiplier (Rs_data)
//   signed_op  in   1    1 = signed operands, sampled with the operands
//   stall      out  1    PC hold request (combinational)
//   busy       out  1    registered, 1 while in RUN
//   done       out  1    registered, 1 for the single DONE cycle
//   result     out  2n   registered product, held until the next DONE
module mul_seq #(
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [n-1:0]     a_in,
    input  logic [n-1:0]     b_in,
    input  logic             signed_op,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [2*n-1:0]   result
);

    localparam int CNT_W = $clog2(n);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(n - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2*n:0]     ACC_ZERO = {(2*n+1){1'b0}};
    localparam logic [2*n-1:0]   RES_ZERO = {(2*n){1'b0}};
    localparam logic [n-1:0]     OPD_ZERO = {n{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [2*n:0]      acc_r;
    logic [n-1:0]      mcand_r;
    logic [n-1:0]      mplier_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*n-1:0]    result_r;
    logic              busy_r;
    logic              done_r;

    logic [n-1:0]      a_mag_s;
    logic [n-1:0]      b_mag_s;
    logic [n:0]        sum_hi_s;
    logic [2*n:0]      acc_add_s;
    logic [2*n:0]      acc_next_s;
    logic [2*n-1:0]    prod_s;
    logic [2*n-1:0]    final_s;
    logic              stall_s;

`ifdef MUL_SIGNED_EN
    logic              neg_r;
    logic              neg_s;

    // Magnitude of an operand; -2^(n-1) maps to 2^(n-1), which still fits in n unsigned bits.
    function automatic logic [n-1:0] mag_f(input logic [n-1:0] v, input logic is_signed);
        logic [n-1:0] m;
        if (is_signed && v[n-1]) begin
            m = (~v) + {{(n-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction
`else
    logic              unused_signed_op_s;
    assign unused_signed_op_s = signed_op;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and the combinational PC hold request.
    always_comb begin
        state_s = state_r;
        stall_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    stall_s = 1'b1;
                end else begin
                    state_s = IDLE;
                    stall_s = 1'b0;
                end
            end
            RUN: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            // DONE never restarts: the multiply opcode is still on the bus here.
            DONE: begin
                state_s = IDLE;
                stall_s = 1'b0;
            end
            default: begin
                state_s = IDLE;
                stall_s = 1'b0;
            end
        endcase
    end

    // Operand conditioning, one shift-add step and the final sign fix-up.
    always_comb begin
`ifdef MUL_SIGNED_EN
        a_mag_s = mag_f(a_in, signed_op);
        b_mag_s = mag_f(b_in, signed_op);
        neg_s   = signed_op & (a_in[n-1] ^ b_in[n-1]);
`else
        a_mag_s = a_in;
        b_mag_s = b_in;
`endif
        // Multiplicand enters at bit n; the right shift brings each partial product into place.
        sum_hi_s = acc_r[2*n:n] + {1'b0, mcand_r};
        if (mplier_r[0]) begin
            acc_add_s = {sum_hi_s, acc_r[n-1:0]};
        end else begin
            acc_add_s = acc_r;
        end
        acc_next_s = {1'b0, acc_add_s[2*n:1]};
        prod_s     = acc_next_s[2*n-1:0];
`ifdef MUL_SIGNED_EN
        if (neg_r) begin
            final_s = (~prod_s) + {{(2*n-1){1'b0}}, 1'b1};
        end else begin
            final_s = prod_s;
        end
`else
        final_s = prod_s;
`endif
    end

    // Datapath registers: operand capture, iteration and result latch on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r    <= ACC_ZERO;
            mcand_r  <= OPD_ZERO;
            mplier_r <= OPD_ZERO;
            cnt_r    <= CNT_ZERO;
            result_r <= RES_ZERO;
`ifdef MUL_SIGNED_EN
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r    <= ACC_ZERO;
                        mcand_r  <= a_mag_s;
                        mplier_r <= b_mag_s;
                        cnt_r    <= CNT_LOAD;
`ifdef MUL_SIGNED_EN
                        neg_r    <= neg_s;
`endif
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= {1'b0, mplier_r[n-1:1]};
                    if (cnt_r == CNT_ZERO) begin
                        result_r <= final_s;
                    end else begin
                        cnt_r    <= cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Registered status flags track the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= (state_s == DONE);
        end
    end

    assign stall  = stall_s;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq (n = 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected values are hand-computed; signed-mode expectations
// depend on whether MUL_SIGNED_EN is defined for the build.
module tb_mul_seq;

    localparam int N = 8;

    logic            clk;
    logic            reset;
    logic            start;
    logic [N-1:0]    a_in;
    logic [N-1:0]    b_in;
    logic            signed_op;
    logic            stall;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  result;

    int n_vec;
    int n_err;

    mul_seq #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .signed_op (signed_op),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; signed_op = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result got=%h exp=0000", result); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
        next_cycle();
    endtask

    // Full cycle-by-cycle timing of 200 x 3; operands are scrambled during RUN.
    task automatic test_unsigned_timing();
        for (int k = 0; k <= 10; k++) begin
            start     = (k == 0);
            signed_op = 1'b0;
            if (k == 0) begin
                a_in = 8'd200; b_in = 8'd3;
            end else begin
                a_in = 8'($urandom); b_in = 8'($urandom);
            end
            @(negedge clk);
            n_vec++;
            if (stall !== (k <= 8)) begin n_err++; $display("FAIL timing_stall k=%0d got=%b exp=%b", k, stall, (k <= 8)); end
            n_vec++;
            if (busy !== (k >= 1 && k <= 8)) begin n_err++; $display("FAIL timing_busy k=%0d got=%b exp=%b", k, busy, (k >= 1 && k <= 8)); end
            n_vec++;
            if (done !== (k == 9)) begin n_err++; $display("FAIL timing_done k=%0d got=%b exp=%b", k, done, (k == 9)); end
            if (k == 9) begin
                n_vec++;
                if (result !== 16'h0258) begin n_err++; $display("FAIL timing_result got=%h exp=0258", result); end
            end
            next_cycle();
        end
    endtask

    // One multiply with a bounded wait for done; checks latency and product.
    task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic sgn, input logic [15:0] exp);
        int lat;
        bit seen;
        a_in = a; b_in = b; signed_op = sgn; start = 1'b1;
        seen = 1'b0;
        lat  = 0;
        next_cycle();
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); signed_op = ~sgn;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!seen && done === 1'b1) begin
                seen = 1'b1;
                lat  = k;
                n_vec++;
                if (result !== exp) begin n_err++; $display("FAIL %s_result got=%h exp=%h", name, result, exp); end
            end
            next_cycle();
            if (seen) k = 21;
        end
        n_vec++;
        if (lat !== 9) begin n_err++; $display("FAIL %s_latency got=%0d exp=9", name, lat); end
    endtask

    task automatic test_signed();
`ifdef MUL_SIGNED_EN
        run_mul("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_mul("s_fbx07", 8'hFB, 8'h07, 1'b1, 16'hFFDD);
        run_mul("s_fdxfc", 8'hFD, 8'hFC, 1'b1, 16'h000C);
        run_mul("s_05xff", 8'h05, 8'hFF, 1'b1, 16'hFFFB);
`else
        run_mul("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_mul("s_fbx07", 8'hFB, 8'h07, 1'b1, 16'h06DD);
        run_mul("s_fdxfc", 8'hFD, 8'hFC, 1'b1, 16'hF90C);
        run_mul("s_05xff", 8'h05, 8'hFF, 1'b1, 16'h04FB);
`endif
        run_mul("u_fbx07", 8'hFB, 8'h07, 1'b0, 16'h06DD);
        run_mul("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    endtask

    // start held through DONE: no restart there, new request accepted at t+10.
    task automatic test_back_to_back();
        for (int k = 0; k <= 20; k++) begin
            start     = (k <= 10);
            signed_op = 1'b0;
            if (k == 0) begin
                a_in = 8'd13; b_in = 8'd11;
            end else if (k >= 9 && k <= 10) begin
                a_in = 8'd0; b_in = 8'd255;
            end else begin
                a_in = 8'($urandom); b_in = 8'($urandom);
            end
            @(negedge clk);
            n_vec++;
            if (done !== (k == 9 || k == 19)) begin n_err++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done, (k == 9 || k == 19)); end
            n_vec++;
            if (busy !== ((k >= 1 && k <= 8) || (k >= 11 && k <= 18))) begin
                n_err++; $display("FAIL b2b_busy k=%0d got=%b", k, busy);
            end
            if (k == 9) begin
                n_vec++;
                if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall_done got=%b exp=0", stall); end
            end
            if (k == 10) begin
                n_vec++;
                if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_idle got=%b exp=1", stall); end
            end
            if (k >= 9 && k <= 18) begin
                n_vec++;
                if (result !== 16'h008F) begin n_err++; $display("FAIL b2b_held k=%0d got=%h exp=008f", k, result); end
            end
            if (k >= 19) begin
                n_vec++;
                if (result !== 16'h0000) begin n_err++; $display("FAIL b2b_zero k=%0d got=%h exp=0000", k, result); end
            end
            next_cycle();
        end
    endtask

    // Reset during the 4th RUN cycle discards the multiply.
    task automatic test_reset_mid();
        run_mul("pre", 8'd7, 8'd9, 1'b0, 16'h003F);
        a_in = 8'd200; b_in = 8'd3; signed_op = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall got=%b exp=0", stall); end
        n_vec++;
        if (result !== 16'h0000) begin n_err++; $display("FAIL rmid_result got=%h exp=0000", result); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin n_err++; $display("FAIL rmid_no_done k=%0d got=%b exp=0", k, done); end
            next_cycle();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_unsigned_timing();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
